// File: rtl/shift_seq_ctrl_amisha_pkg.sv
// Shared definitions for the shift sequencer and the universal shift register:
// sequencer state encodings and shift-register command codes.
package shift_seq_ctrl_amisha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_t;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_SHL  = 2'b01;
  localparam logic [1:0] CTRL_SHR  = 2'b10;
  localparam logic [1:0] CTRL_LOAD = 2'b11;

endpackage

// File: rtl/shift_seq_ctrl_amisha_bit_cnt.sv
// Bit counter for the SHIFT phase: clear, enable, terminal count at N_amisha-1.
module shift_bit_cnt_amisha #(
  parameter int N_amisha  = 8,
  parameter int CW_amisha = $clog2(N_amisha)
) (
  input  logic clk_amisha,
  input  logic reset_n_amisha,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW_amisha-1:0] cnt_r;

  // Count register; clear has priority over enable.
  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CW_amisha'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == CW_amisha'(N_amisha - 1));

endmodule

// File: rtl/shift_seq_ctrl_amisha.sv
// Parallel-to-serial sequencer driving an N-bit universal shift register.
// Optional macro SHIFT_SEQ_ROTATE_EN feeds the shifted-out bit back as fill (rotate).
module shift_seq_ctrl_amisha #(
  parameter int N_amisha = 8
) (
  input  logic                clk_amisha,
  input  logic                reset_n_amisha,
  input  logic                in_valid_amisha,
  output logic                in_ready_amisha,
  input  logic [N_amisha-1:0] in_data_amisha,
  input  logic                in_dir_amisha,
  output logic [1:0]          ctrl_amisha,
  output logic [N_amisha-1:0] d_amisha,
  input  logic [N_amisha-1:0] q_amisha,
  output logic                ser_out_amisha,
  output logic                ser_valid_amisha,
  output logic                busy_amisha,
  output logic                done_amisha
);
  import shift_seq_ctrl_amisha_pkg::*;

  seq_state_t          state_r;
  seq_state_t          state_nxt_s;
  logic [N_amisha-1:0] data_r;
  logic                dir_r;
  logic                hs_s;
  logic                tc_s;
  logic                fill_s;
  logic                unused_q_s;

  assign hs_s           = in_valid_amisha && (state_r == ST_IDLE);
  assign ser_out_amisha = dir_r ? q_amisha[0] : q_amisha[N_amisha-1];
  assign unused_q_s     = ^q_amisha;

`ifdef SHIFT_SEQ_ROTATE_EN
  assign fill_s = ser_out_amisha;
`else
  assign fill_s = 1'b0;
`endif

  shift_bit_cnt_amisha #(.N_amisha(N_amisha)) u_bit_cnt (
    .clk_amisha     (clk_amisha),
    .reset_n_amisha (reset_n_amisha),
    .clr            (state_r != ST_SHIFT),
    .en             (state_r == ST_SHIFT),
    .tc             (tc_s)
  );

  // State register.
  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Word and direction captured only at the handshake.
  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      data_r <= '0;
      dir_r  <= 1'b0;
    end else if (hs_s) begin
      data_r <= in_data_amisha;
      dir_r  <= in_dir_amisha;
    end else begin
      data_r <= data_r;
      dir_r  <= dir_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: state_nxt_s = ST_SHIFT;
      ST_SHIFT: begin
        if (tc_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Moore output decode.
  always_comb begin
    ctrl_amisha      = CTRL_HOLD;
    d_amisha         = '0;
    in_ready_amisha  = 1'b0;
    busy_amisha      = 1'b0;
    done_amisha      = 1'b0;
    ser_valid_amisha = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_amisha = 1'b1;
      ST_LOAD: begin
        ctrl_amisha = CTRL_LOAD;
        d_amisha    = data_r;
        busy_amisha = 1'b1;
      end
      ST_SHIFT: begin
        busy_amisha      = 1'b1;
        ser_valid_amisha = 1'b1;
        if (dir_r) begin
          ctrl_amisha           = CTRL_SHR;
          d_amisha[N_amisha-1]  = fill_s;
        end else begin
          ctrl_amisha           = CTRL_SHL;
          d_amisha[0]           = fill_s;
        end
      end
      ST_DONE: begin
        busy_amisha = 1'b1;
        done_amisha = 1'b1;
      end
      default: in_ready_amisha = 1'b0;
    endcase
  end

endmodule
